// File: rtl/t06_debounce.sv
// Multi-channel button debouncer: 2-flop synchronizer, shared sample-tick prescaler,
// and per-channel STABLE/PENDING filter producing clean levels and edge pulses.
module t06_debounce #(
    parameter int NUM_BTN      = 4,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_clean,
    output logic [NUM_BTN-1:0] btn_rise,
    output logic [NUM_BTN-1:0] btn_fall
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [NUM_BTN-1:0] sync_meta;
    logic [NUM_BTN-1:0] sync;
    logic [PW-1:0]      pre_cnt;
    logic               tick;
    logic [NUM_BTN-1:0] accept;

    state_t        state_q [NUM_BTN];
    state_t        state_d [NUM_BTN];
    logic [CW-1:0] cnt_q   [NUM_BTN];
    logic [CW-1:0] cnt_d   [NUM_BTN];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two synchronizer stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= btn_in;
            sync      <= sync_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PW'(TICK_DIV - 1)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    assign tick = (pre_cnt == PW'(TICK_DIV - 1));

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (sync[i] != btn_clean[i]) begin
                        state_d[i] = ST_PENDING;
                        cnt_d[i]   = '0;
                    end
                end
                ST_PENDING: begin
                    if (sync[i] == btn_clean[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (tick) begin
                        // Accept on the tick that would make the count reach STABLE_TICKS.
                        if (cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
                            accept[i]  = 1'b1;
                            state_d[i] = ST_STABLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // NOTE: the per-channel arrays are plain flops, not a RAM, so they are reset
    // like any other state; this is what lets reset discard a pending change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Pulses are registered alongside btn_clean so they coincide with the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_clean <= '0;
            btn_rise  <= '0;
            btn_fall  <= '0;
        end else begin
            btn_clean <= btn_clean ^ accept;
            btn_rise  <= accept & ~btn_clean;
            btn_fall  <= accept & btn_clean;
        end
    end

endmodule

// File: doc/t06_debounce.md
T06_DEBOUNCE -- requirements
Module: t06_debounce

Interface
REQ-001 The block SHALL have parameter NUM_BTN, default 4, giving the number of independent button channels (legal 1..16).
REQ-002 The block SHALL have parameter TICK_DIV, default 1000, giving the clk cycles per sample tick (legal >= 1; 1 = tick every cycle).
REQ-003 The block SHALL have parameter STABLE_TICKS, default 8, giving the consecutive mismatching ticks required to accept a level change (legal >= 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port btn_in, input, NUM_BTN bits: raw, asynchronous button levels.
REQ-007 The block SHALL have port btn_clean, output, NUM_BTN bits: debounced level per channel; this is the input to the downstream edge detector.
REQ-008 The block SHALL have port btn_rise, output, NUM_BTN bits: one-cycle pulse per channel on an accepted 0->1 change.
REQ-009 The block SHALL have port btn_fall, output, NUM_BTN bits: one-cycle pulse per channel on an accepted 1->0 change.

Function
REQ-010 Each btn_in bit SHALL pass through a 2-flop synchronizer; only the second-flop value (sync) SHALL be used downstream.
REQ-011 A shared prescaler SHALL count 0..TICK_DIV-1 and wrap to 0, asserting an internal tick for exactly one cycle when count == TICK_DIV-1.
REQ-012 Each channel SHALL hold a 2-state FSM: STABLE and PENDING.
REQ-013 In STABLE, sync == btn_clean SHALL keep STABLE; sync != btn_clean SHALL go to PENDING with the channel counter at 0.
REQ-014 In PENDING, sync == btn_clean in any cycle SHALL return to STABLE and clear the counter (glitch rejected, no output change).
REQ-015 In PENDING with sync != btn_clean, the counter SHALL increment on each tick cycle and hold otherwise.
REQ-016 On the tick where the counter would reach STABLE_TICKS, btn_clean SHALL toggle in the next cycle, the counter SHALL clear, and the FSM SHALL return to STABLE.
REQ-017 btn_rise/btn_fall SHALL be registered and asserted in exactly the cycle in which btn_clean first shows the new value, for one cycle only.
REQ-018 The channel counter width SHALL be clog2(STABLE_TICKS+1) and SHALL never wrap.
REQ-019 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce pulses in the same cycle on each.
REQ-020 btn_rise and btn_fall SHALL never both be asserted for one channel in the same cycle.
REQ-021 Latency from a btn_in change held stable to the btn_clean change SHALL be between 2+(STABLE_TICKS-1)*TICK_DIV+1 and 2+STABLE_TICKS*TICK_DIV+1 cycles, inclusive.

Reset
REQ-022 While rst is high, synchronizer flops, prescaler, counters, btn_clean, btn_rise and btn_fall SHALL be 0 and all FSMs SHALL be STABLE, independent of clk.
REQ-023 Assertion of rst during PENDING SHALL discard the pending change; no pulse SHALL be emitted for it.
REQ-024 A btn_in bit held high across reset release SHALL be treated as a new press: btn_clean rises after the normal filter delay with one btn_rise pulse.

Verification (TICK_DIV=4, STABLE_TICKS=3)
REQ-025 Reset: rst=1, btn_in=4'b1111 -> all outputs 0; release rst -> btn_clean=4'b1111 and btn_rise=4'b1111 for one cycle, within 11..15 cycles of release.
REQ-026 Press: btn_in[0] 0->1 held -> btn_clean[0]=1 within 11..15 cycles, btn_rise[0] high exactly one cycle, btn_fall=0 throughout.
REQ-027 Glitch: btn_in[1] high for 5 cycles then low -> btn_clean, btn_rise and btn_fall stay 0.
REQ-028 Release: btn_in[0] 1->0 held after an accepted press -> btn_clean[0]=0 within 11..15 cycles with one btn_fall[0] pulse.
REQ-029 Simultaneous: btn_in[2] and btn_in[3] rise in the same cycle -> btn_rise=4'b1100 in a single cycle.
REQ-030 Reset mid-pending: btn_in[0] rises, rst pulsed 8 cycles later -> no btn_rise[0] pulse from the first attempt; a fresh filter delay is measured from rst release.
